// File: rtl/mem_arbiter_if.sv
// Memory request/response bus bundle; NUM_CH channels packed side by side.
interface mem_arbiter_if #(
   parameter int unsigned NUM_CH     = 1,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [NUM_CH*ADDR_WIDTH-1:0] m_address;
   logic [NUM_CH*DATA_WIDTH-1:0] m_data;
   logic [NUM_CH-1:0]            m_write;
   logic [NUM_CH-1:0]            m_valid;
   logic [NUM_CH-1:0]            m_ready;
   logic [NUM_CH*DATA_WIDTH-1:0] s_data;
   logic [NUM_CH-1:0]            s_valid;
   logic [NUM_CH-1:0]            s_ready;

   // Issues requests, consumes responses
   modport master (
      output m_address, m_data, m_write, m_valid, s_ready,
      input  m_ready, s_data, s_valid
   );

   // Accepts requests, returns responses
   modport slave (
      input  m_address, m_data, m_write, m_valid, s_ready,
      output m_ready, s_data, s_valid
   );
endinterface

// File: rtl/mem_arbiter.sv
// N-to-1 round-robin memory arbiter with locked grant and in-order read-ID FIFO.
module mem_arbiter #(
   parameter int unsigned NUM_MASTERS     = 2,
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   mem_arbiter_if.slave                      up,
   mem_arbiter_if.master                     dn,
   output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
   output logic                              err_unexpected
);
   localparam int unsigned ID_W  = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
   localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic                   r_locked;
   logic [ID_W-1:0]        r_grant;
   logic [ID_W-1:0]        r_rr_ptr;
   logic [ID_W-1:0]        r_fifo [MAX_OUTSTANDING];
   logic [PTR_W-1:0]       r_head;
   logic [PTR_W-1:0]       r_tail;
   logic [CNT_W-1:0]       r_count;
   logic                   r_err;

   logic                   w_xfer;
   logic                   w_arb_en;
   logic                   w_full;
   logic [NUM_MASTERS-1:0] w_elig;
   logic                   w_found;
   logic [ID_W-1:0]        w_win;
   logic                   w_locked_nxt;
   logic [ID_W-1:0]        w_grant_nxt;
   logic [ID_W-1:0]        w_rr_nxt;
   logic                   w_push;
   logic                   w_pop;
   logic [PTR_W-1:0]       w_head_nxt;
   logic [PTR_W-1:0]       w_tail_nxt;
   logic [CNT_W-1:0]       w_count_nxt;
   logic                   w_err_nxt;
   logic [ID_W-1:0]        w_head;
   logic                   w_dn_s_ready;

   // Round-robin search for the next eligible master, starting after rr_ptr
   always_comb begin : p_arb
      int unsigned v_idx;
      logic [ID_W-1:0] v_sel;
      w_xfer   = r_locked && dn.m_ready[0];
      w_arb_en = !r_locked || w_xfer;
      w_full   = (r_count == CNT_W'(MAX_OUTSTANDING));
      w_found  = 1'b0;
      w_win    = '0;
      v_idx    = 0;
      v_sel    = '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         w_elig[i] = up.m_valid[i] && (up.m_write[i] || !w_full)
                     && !(w_xfer && (r_grant == ID_W'(i)));
      end
      for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
         v_idx = (32'(r_rr_ptr) + k) % NUM_MASTERS;
         v_sel = ID_W'(v_idx);
         if (!w_found && w_elig[v_sel]) begin
            w_found = 1'b1;
            w_win   = v_sel;
         end
      end
   end

   // Next-state: grant lock, ID FIFO push/pop, sticky error
   always_comb begin : p_next
      w_locked_nxt = r_locked;
      w_grant_nxt  = r_grant;
      w_rr_nxt     = r_rr_ptr;
      w_push       = 1'b0;
      if (w_arb_en) begin
         w_locked_nxt = w_found;
         if (w_found) begin
            w_grant_nxt = w_win;
            w_rr_nxt    = w_win;
            w_push      = !up.m_write[w_win];
         end
      end
      w_pop       = dn.s_valid[0] && w_dn_s_ready && (r_count != '0);
      w_head_nxt  = w_pop  ? r_head + PTR_W'(1) : r_head;
      w_tail_nxt  = w_push ? r_tail + PTR_W'(1) : r_tail;
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
      w_err_nxt = r_err || (dn.s_valid[0] && (r_count == '0));
   end

   // State register with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         r_locked <= 1'b0;
         r_grant  <= '0;
         r_rr_ptr <= ID_W'(NUM_MASTERS - 1);
         r_head   <= '0;
         r_tail   <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_locked <= w_locked_nxt;
         r_grant  <= w_grant_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_head   <= w_head_nxt;
         r_tail   <= w_tail_nxt;
         r_count  <= w_count_nxt;
         r_err    <= w_err_nxt;
      end
   end

   // ID FIFO storage; contents are don't-care while unoccupied
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo[r_tail] <= w_win;
      end
   end

   // Request mux from the locked grant and response routing by FIFO head
   always_comb begin : p_out
      w_head        = r_fifo[r_head];
      w_dn_s_ready  = (r_count == '0) ? 1'b1 : up.s_ready[w_head];
      dn.m_valid[0] = r_locked;
      dn.m_address  = up.m_address[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
      dn.m_data     = up.m_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
      dn.m_write[0] = up.m_write[r_grant];
      dn.s_ready[0] = w_dn_s_ready;
      up.s_data     = {NUM_MASTERS{dn.s_data}};
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
         up.m_ready[i] = r_locked && dn.m_ready[0] && (r_grant == ID_W'(i));
         up.s_valid[i] = dn.s_valid[0] && (r_count != '0) && (w_head == ID_W'(i));
      end
   end

   assign outstanding    = r_count;
   assign err_unexpected = r_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with two masters and a 4-deep ID FIFO.
module tb_mem_arbiter;
   localparam int unsigned NM = 2;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned MO = 4;
   localparam logic [31:0] A0 = 32'h1000_0040;
   localparam logic [31:0] A1 = 32'h2000_0080;
   localparam logic [31:0] D0 = 32'hCAFE_0000;
   localparam logic [31:0] D1 = 32'hBEEF_0001;

   typedef struct packed {
      logic [1:0]  v;
      logic [1:0]  w;
      logic        dmr;
      logic        dsv;
      logic [31:0] dsd;
      logic [1:0]  usr;
      logic        e_dmv;
      logic [31:0] e_addr;
      logic [1:0]  e_umr;
      logic [1:0]  e_usv;
      logic        e_dsr;
      logic [2:0]  e_out;
      logic        e_err;
   } vec_t;

   localparam int NV = 13;
   vec_t tbl [NV];

   logic       clock = 1'b0;
   logic       reset;
   logic [2:0] outstanding;
   logic       err_unexpected;
   int         n_checks;
   int         n_errors;

   mem_arbiter_if #(.NUM_CH(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) up_if ();
   mem_arbiter_if #(.NUM_CH(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn_if ();

   mem_arbiter #(
      .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clock(clock),
      .reset(reset),
      .up(up_if),
      .dn(dn_if),
      .outstanding(outstanding),
      .err_unexpected(err_unexpected)
   );

   always #5 clock = ~clock;

   assign up_if.m_address = {A1, A0};
   assign up_if.m_data    = {D1, D0};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic dmr,
                        input logic dsv, input logic [31:0] dsd, input logic [1:0] usr);
      up_if.m_valid  = v;
      up_if.m_write  = w;
      dn_if.m_ready  = dmr;
      dn_if.s_valid  = dsv;
      dn_if.s_data   = dsd;
      up_if.s_ready  = usr;
      #1;
   endtask

   task automatic tick;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_bus(input string tag, input logic e_dmv, input logic [31:0] e_addr,
                          input logic [1:0] e_umr, input logic [2:0] e_out);
      chk({tag, " dn_m_valid"}, dn_if.m_valid, e_dmv);
      if (e_dmv) chk({tag, " dn_m_address"}, dn_if.m_address, e_addr);
      chk({tag, " up_m_ready"}, up_if.m_ready, e_umr);
      chk({tag, " outstanding"}, outstanding, e_out);
   endtask

   task automatic chk_rsp(input string tag, input logic [1:0] e_usv, input logic e_dsr,
                          input logic e_err);
      chk({tag, " up_s_valid"}, up_if.s_valid, e_usv);
      chk({tag, " dn_s_ready"}, dn_if.s_ready, e_dsr);
      chk({tag, " err_unexpected"}, err_unexpected, e_err);
      chk({tag, " up_s_data"}, up_if.s_data, {dn_if.s_data, dn_if.s_data});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      //           v      w      dmr   dsv   dsd    usr    dmv   addr usr   usv    dsr   out   err
      tbl[0]  = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0, A0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0};
      tbl[1]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0, A0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0};
      tbl[2]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, A0, 2'b01, 2'b00, 1'b1, 3'd1, 1'b0};
      tbl[3]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, A1, 2'b10, 2'b00, 1'b1, 3'd2, 1'b0};
      tbl[4]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, A0, 2'b01, 2'b00, 1'b1, 3'd3, 1'b0};
      tbl[5]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b1, A1, 2'b10, 2'b00, 1'b1, 3'd4, 1'b0};
      tbl[6]  = '{2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0, A0, 2'b00, 2'b00, 1'b1, 3'd4, 1'b0};
      tbl[7]  = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hA, 2'b11, 1'b0, A0, 2'b00, 2'b01, 1'b1, 3'd4, 1'b0};
      tbl[8]  = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hB, 2'b11, 1'b0, A0, 2'b00, 2'b10, 1'b1, 3'd3, 1'b0};
      tbl[9]  = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hC, 2'b01, 1'b0, A0, 2'b00, 2'b01, 1'b1, 3'd2, 1'b0};
      tbl[10] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hD, 2'b01, 1'b0, A0, 2'b00, 2'b10, 1'b0, 3'd1, 1'b0};
      tbl[11] = '{2'b00, 2'b00, 1'b1, 1'b1, 32'hD, 2'b11, 1'b0, A0, 2'b00, 2'b10, 1'b1, 3'd1, 1'b0};
      tbl[12] = '{2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0, A0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0};

      reset = 1'b1;
      drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      tick();
      tick();
      reset = 1'b0;

      // Idle after reset
      for (int c = 0; c < 10; c++) begin
         drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
         chk_bus($sformatf("idle%0d", c), 1'b0, A0, 2'b00, 3'd0);
         chk_rsp($sformatf("idle%0d", c), 2'b00, 1'b1, 1'b0);
         tick();
      end

      // Alternating reads up to full FIFO, then in-order responses with backpressure
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].v, tbl[i].w, tbl[i].dmr, tbl[i].dsv, tbl[i].dsd, tbl[i].usr);
         chk_bus($sformatf("vec%0d", i), tbl[i].e_dmv, tbl[i].e_addr, tbl[i].e_umr, tbl[i].e_out);
         chk_rsp($sformatf("vec%0d", i), tbl[i].e_usv, tbl[i].e_dsr, tbl[i].e_err);
         tick();
      end

      // Full FIFO blocks reads but not writes; a pop frees the slot one cycle later
      do_reset();
      for (int k = 0; k < 8; k++) begin
         drive(2'b10, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
         chk_bus($sformatf("fill%0d", k), 1'(k % 2), A1, (k % 2 == 1) ? 2'b10 : 2'b00, 3'((k + 1) / 2));
         tick();
      end
      drive(2'b11, 2'b10, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("full_arb", 1'b0, A1, 2'b00, 3'd4);
      tick();
      drive(2'b11, 2'b10, 1'b1, 1'b1, 32'h55, 2'b11);
      chk_bus("full_wr", 1'b1, A1, 2'b10, 3'd4);
      chk("full_wr dn_m_write", dn_if.m_write, 1'b1);
      chk("full_wr dn_m_data", dn_if.m_data, D1);
      chk_rsp("full_wr", 2'b10, 1'b1, 1'b0);
      tick();
      drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("full_pop", 1'b0, A0, 2'b00, 3'd3);
      tick();
      drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("full_rd", 1'b1, A0, 2'b01, 3'd4);
      chk("full_rd dn_m_write", dn_if.m_write, 1'b0);
      chk("full_rd dn_m_data", dn_if.m_data, D0);
      tick();

      // Reads M0, M1, M0; M1 stalls its response for three cycles
      do_reset();
      drive(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("ord0", 1'b0, A0, 2'b00, 3'd0);
      tick();
      drive(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("ord1", 1'b1, A0, 2'b01, 3'd1);
      tick();
      drive(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("ord2", 1'b1, A1, 2'b10, 3'd2);
      tick();
      drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("ord3", 1'b1, A0, 2'b01, 3'd3);
      tick();
      drive(2'b00, 2'b00, 1'b1, 1'b1, 32'hA, 2'b01);
      chk_bus("rspA", 1'b0, A0, 2'b00, 3'd3);
      chk_rsp("rspA", 2'b01, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(2'b00, 2'b00, 1'b1, 1'b1, 32'hB, 2'b01);
         chk_rsp($sformatf("holdB%0d", k), 2'b10, 1'b0, 1'b0);
         chk($sformatf("holdB%0d outstanding", k), outstanding, 3'd2);
         tick();
      end
      drive(2'b00, 2'b00, 1'b1, 1'b1, 32'hB, 2'b11);
      chk_rsp("rspB", 2'b10, 1'b1, 1'b0);
      tick();
      drive(2'b00, 2'b00, 1'b1, 1'b1, 32'hC, 2'b01);
      chk_rsp("rspC", 2'b01, 1'b1, 1'b0);
      chk("rspC outstanding", outstanding, 3'd1);
      tick();
      drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk("ord_done outstanding", outstanding, 3'd0);
      tick();

      // Locked grant holds payload under downstream stall
      do_reset();
      drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11);
      chk_bus("lock0", 1'b0, A0, 2'b00, 3'd0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         logic [1:0] vv;
         vv = {k[0], 1'b1};
         drive(vv, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11);
         chk_bus($sformatf("stall%0d", k), 1'b1, A0, 2'b00, 3'd1);
         tick();
      end
      drive(2'b11, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("unstall", 1'b1, A0, 2'b01, 3'd1);
      tick();
      drive(2'b10, 2'b00, 1'b0, 1'b0, 32'h0, 2'b11);
      chk_bus("next_m1", 1'b1, A1, 2'b00, 3'd2);

      // Reset mid-operation discards grant and pending IDs
      do_reset();
      drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_bus("midrst", 1'b0, A0, 2'b00, 3'd0);
      chk_rsp("midrst", 2'b00, 1'b1, 1'b0);

      // Unexpected response is consumed and flagged until reset
      drive(2'b00, 2'b00, 1'b1, 1'b1, 32'h77, 2'b00);
      chk_rsp("unexp", 2'b00, 1'b1, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
         chk_rsp($sformatf("sticky%0d", k), 2'b00, 1'b1, 1'b1);
         chk($sformatf("sticky%0d outstanding", k), outstanding, 3'd0);
         tick();
      end
      do_reset();
      drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0, 2'b11);
      chk_rsp("err_clr", 2'b00, 1'b1, 1'b0);
      chk("err_clr outstanding", outstanding, 3'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-to-1 arbiter for the Memory request/response bus.
- Lets several masters (instruction fetch, data port, DMA, debug) share one memory port.
- Round-robin request arbitration with a locked grant.
- Read responses return in order; an ID FIFO routes each one back to the master that issued it.
- Writes produce no response.

Parameters:
NUM_MASTERS, 2, number of upstream master channels (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width
MAX_OUTSTANDING, 4, ID FIFO depth = max reads awaiting response (power of 2, >=2)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high
up_m_address  input  NUM_MASTERS*ADDR_WIDTH  per-master request address, master i at slice i
up_m_data  input  NUM_MASTERS*DATA_WIDTH  per-master write data
up_m_write  input  NUM_MASTERS  1=write, 0=read
up_m_valid  input  NUM_MASTERS  request valid
up_m_ready  output  NUM_MASTERS  request accepted
up_s_data  output  NUM_MASTERS*DATA_WIDTH  read response data
up_s_valid  output  NUM_MASTERS  response valid
up_s_ready  input  NUM_MASTERS  master can take response
dn_m_address  output  ADDR_WIDTH  memory request address
dn_m_data  output  DATA_WIDTH  memory write data
dn_m_write  output  1  memory write flag
dn_m_valid  output  1  memory request valid
dn_m_ready  input  1  memory accepts request
dn_s_data  input  DATA_WIDTH  memory read data
dn_s_valid  input  1  memory response valid
dn_s_ready  output  1  arbiter accepts response
outstanding  output  $clog2(MAX_OUTSTANDING)+1  current ID FIFO occupancy
err_unexpected  output  1  sticky: response arrived with FIFO empty

Behaviour:
- Transfer rule: every channel transfers on a cycle where valid && ready. Masters and memory hold valid and payload stable until the transfer.
- State: locked (1b), grant (ID_W = max(1,$clog2(NUM_MASTERS))), rr_ptr (last granted index), ID FIFO with head/tail/count, err_unexpected.
- Reset values:
  - locked=0, rr_ptr=NUM_MASTERS-1 (master 0 wins first), FIFO empty, err_unexpected=0.
  - Hence dn_m_valid=0, up_m_ready=0, up_s_valid=0, dn_s_ready=1, outstanding=0.
- Eligibility: master i is eligible iff up_m_valid[i] && (up_m_write[i] || count<MAX_OUTSTANDING).
- Arbitration happens on any cycle where locked=0, or where the locked request transfers downstream this cycle.
  - The grant goes to the first eligible master scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_MASTERS.
  - A master whose request transfers this cycle is excluded from that cycle's arbitration.
  - The result registers at the next edge: locked<=1, grant<=i, rr_ptr<=i.
  - If no master is eligible: locked<=0.
  - Arbitration latency is 1 cycle.
  - Back-to-back throughput is one request per cycle across different masters, and one per 2 cycles for a single master.
- On a read grant, push i into the ID FIFO at the same edge that sets locked. Reservation happens at grant, so a full FIFO blocks only reads; writes keep flowing.
- Request path (combinational from state):
  - dn_m_valid = locked.
  - dn_m_address, dn_m_data and dn_m_write are the slices of master grant.
  - up_m_ready[grant] = locked && dn_m_ready; all other up_m_ready bits = 0.
- Grant stability: grant, and therefore the dn_m_* payload, never changes while dn_m_valid=1 and dn_m_ready=0.
- Response path (combinational):
  - head = ID at FIFO head.
  - up_s_data[i] = dn_s_data for all i.
  - up_s_valid[i] = dn_s_valid && count>0 && head==i.
  - dn_s_ready = (count==0) ? 1 : up_s_ready[head].
  - Pop on dn_s_valid && dn_s_ready && count>0.
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo MAX_OUTSTANDING.
- Full FIFO:
  - No read is granted, even when a pop occurs in the same cycle.
  - A pop frees the slot for the following cycle's arbitration.
- Unexpected response: dn_s_valid with count==0 is consumed (dn_s_ready=1), dropped, and sets err_unexpected=1 until reset.
- Reset mid-operation:
  - All state returns to reset values at the edge; in-flight grants and pending IDs are discarded.
  - Memory must be reset at the same time. Stale responses after reset assert err_unexpected.
- outstanding = count (0..MAX_OUTSTANDING).

Test Plan:
- Reset, then all up_m_valid=0 -> dn_m_valid=0, up_m_ready=0, dn_s_ready=1, outstanding=0, err_unexpected=0 for 10 cycles.
- Masters 0 and 1 each hold read requests valid continuously, dn_m_ready=1 -> grants alternate 0,1,0,1; the first dn_m_valid appears 1 cycle after valid; outstanding increments per grant.
- 4 reads issued by master 1 (MAX_OUTSTANDING=4), no responses, master 0 then requests a read and master 1 a write -> master 0's read is blocked and the write is granted. The first response pops and outstanding drops 4->3; master 0's read is granted the next cycle.
- Reads granted in order M0, M1, M0; responses 0xA, 0xB, 0xC with up_s_ready[1]=0 for 3 cycles -> 0xA goes to M0; 0xB is held (dn_s_ready=0, up_s_valid[1]=1) until ready; then 0xC goes to M0.
- Locked request with dn_m_ready=0 for 5 cycles while other masters toggle valid -> dn_m_address and grant stay constant until transfer.
- dn_s_valid=1 with FIFO empty -> dn_s_ready=1, all up_s_valid=0, err_unexpected=1 thereafter. Assert reset mid-stream -> err_unexpected=0 and outstanding=0 after the edge.
